// File: rtl/tinyrv_pkg.sv
// ==== tinyrv_pkg : shared widths, fetch state encoding and helpers ==== rev 1.0
// Imported by inst_fetch and fetch_fifo.
`default_nettype none

package tinyrv_pkg;

  localparam int XLEN   = 32;
  localparam int ILEN   = 32;
  localparam int DROP_W = 16;
  localparam logic [ILEN-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ==== fetch_fifo : synchronous prefetch FIFO with flush, simultaneous push/pop ==== rev 1.0
// Read data is the registered head entry; count/full/empty are registered.
`default_nettype none

module fetch_fifo
  import tinyrv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ==== inst_fetch : instruction fetch stage (PC, request credit, redirect flush, prefetch FIFO) ==== rev 1.0
// Optional macro FETCH_MISALIGN_CHECK_EN adds fetch_misalign and halts on unaligned redirect targets.
`default_nettype none

module inst_fetch
  import tinyrv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            fetch_misalign,
`endif
  output logic            inst_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = XLEN + ILEN + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

  fetch_state_e    state;
  fetch_state_e    state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redir_target;
  logic            redir_bad;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   fifo_count;
  logic [DROP_W-1:0] drop_cnt;
  logic            req_hs;
  logic            rsp_accept;
  logic            rsp_keep;
  logic [ILEN-1:0] rsp_word;
  logic [EW-1:0]   push_data;
  logic [EW-1:0]   head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_target = redirect_pc;
  assign redir_bad    = (redirect_pc[1:0] != 2'b00);
`else
  assign redir_target = word_align(redirect_pc);
  assign redir_bad    = 1'b0;
`endif

  // Credit counts FIFO occupancy plus in-flight kept requests, so every response finds a slot.
  assign imem_req_valid = rst_n && (state == ST_RUN) && !redirect_valid &&
                          (({1'b0, outstanding} + {1'b0, fifo_count}) < CREDIT_MAX);
  assign imem_req_addr  = word_align(pc);
  assign req_hs         = imem_req_valid && imem_req_ready;

  // Responses owed to a flushed stream are consumed by drop_cnt before any count as kept.
  assign rsp_accept = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign rsp_keep   = rsp_accept && (state == ST_RUN);
  assign rsp_word   = imem_rsp_err ? '0 : imem_rsp_data;
  assign push_data  = {rsp_pc, rsp_word, imem_rsp_err};
  assign fifo_push  = rsp_keep && !fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = redir_bad ? ST_HALT : ST_RUN;
    end else if (rsp_keep && imem_rsp_err) begin
      state_nxt = ST_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      pc          <= redir_target;
      rsp_pc      <= redir_target;
      outstanding <= '0;
      // Everything still owed by memory is discarded; a response landing now is dropped here.
      drop_cnt    <= drop_cnt + DROP_W'(outstanding) + DROP_W'(req_hs)
                     - DROP_W'(imem_rsp_valid);
    end else begin
      if (req_hs)   pc     <= pc + XLEN'(4);
      if (rsp_keep) rsp_pc <= rsp_pc + XLEN'(4);
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      outstanding <= outstanding + CW'(req_hs) - CW'(rsp_accept);
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_misalign <= 1'b0;
    end else begin
      fetch_misalign <= redirect_valid && redir_bad;
    end
  end
`endif

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (inst_ready),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign inst_valid = !fifo_empty;
  assign inst_pc    = fifo_empty ? '0 : head[EW-1 -: XLEN];
  assign inst       = fifo_empty ? '0 : head[ILEN:1];
  assign inst_err   = !fifo_empty && head[0];

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ==== tb_inst_fetch : randomized scoreboard bench for inst_fetch ==== rev 1.0
// Memory model answers in order with random latency; an epoch-tagged model predicts the stream.
`default_nettype none

module tb_inst_fetch;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready, inst_err;
  logic [31:0] inst, inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  inst_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
    .fetch_misalign (fetch_misalign),
`endif
    .inst_err       (inst_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic err; int epoch; int due;} mreq_t;
  typedef struct {logic [31:0] pc; logic [31:0] data; logic err;} exp_t;

  mreq_t pend[$];
  exp_t  sb[$];
  int    cyc = 0;
  int    checks = 0;
  int    fails = 0;
  int    cur_epoch = 0;
  int    last_due = 0;
  int    sb_before = 0;
  logic  halted = 1'b0;
  logic  exp_mis = 1'b0;
  logic [31:0] model_pc = RST_PC;

  int unsigned p_iready = 100, p_qready = 100, p_redir = 0, p_err = 0, max_lat = 0;
  logic        auto_unhalt = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic        force_redir = 1'b0;
  logic [31:0] force_pc = '0;
  logic        rsp_now = 1'b0;
  mreq_t       rsp_cur;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    if ($urandom_range(3) == 0) p = 32'hFFFF_FFF0 | 32'($urandom_range(15));
    else                        p = 32'($urandom_range(4095));
`ifdef FETCH_MISALIGN_CHECK_EN
    p[1:0] = 2'b00;
`endif
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Stimulus: memory responder plus decoder/redirect drivers, all changing at negedge.
  initial begin : driver
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    forever begin
      @(negedge clk);
      rsp_now = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
      if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
        rsp_cur = pend.pop_front();
        rsp_now = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_of(rsp_cur.addr);
        imem_rsp_err   = rsp_cur.err;
      end
      imem_req_ready = rst_n && ($urandom_range(99) < p_qready);
      inst_ready     = ($urandom_range(99) < p_iready);
      redirect_valid = 1'b0;
      if (force_redir) begin
        redirect_valid = 1'b1; redirect_pc = force_pc; force_redir = 1'b0;
      end else if (rst_n && (($urandom_range(999) < p_redir) ||
                             (halted && auto_unhalt && $urandom_range(7) == 0))) begin
        redirect_valid = 1'b1; redirect_pc = rand_pc();
      end
    end
  end

  // Reference model: requests tagged with the redirect epoch; only current-epoch responses survive.
  initial begin : model
    int          n;
    int          due;
    logic        exp_rv;
    logic        e;
    forever begin
      @(negedge clk); #3;
      if (!rst_n) continue;
`ifdef FETCH_MISALIGN_CHECK_EN
      check("fetch_misalign", 32'(fetch_misalign), 32'(exp_mis));
      exp_mis = 1'b0;
`endif
      sb_before = sb.size();
      n = 0;
      foreach (pend[i]) if (pend[i].epoch == cur_epoch) n++;
      if (rsp_now && rsp_cur.epoch == cur_epoch) n++;
      exp_rv = !halted && !redirect_valid && (n + sb_before < DEPTH);
      check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, model_pc);
        due = cyc + 1 + int'($urandom_range(max_lat));
        if (due < last_due) due = last_due;
        last_due = due;
        e = (model_pc == err_addr) || ($urandom_range(99) < p_err);
        pend.push_back('{addr: model_pc, err: e, epoch: cur_epoch, due: due});
        model_pc = model_pc + 32'd4;
      end
      if (rsp_now && rsp_cur.epoch == cur_epoch && !halted && !redirect_valid) begin
        sb.push_back('{pc: rsp_cur.addr, data: rsp_cur.err ? 32'h0 : word_of(rsp_cur.addr),
                       err: rsp_cur.err});
        if (rsp_cur.err) halted = 1'b1;
      end
      if (redirect_valid) begin
        cur_epoch++;
        sb.delete();
        halted   = 1'b0;
        model_pc = redirect_pc & ~32'h3;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (redirect_pc[1:0] != 2'b00) begin
          halted  = 1'b1;
          exp_mis = 1'b1;
        end
`endif
      end
    end
  end

  // Monitor: compares the decoder-side stream against the scoreboard.
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk); #4;
      if (!rst_n) continue;
      check("inst_valid", 32'(inst_valid), 32'(sb_before != 0));
      if (inst_valid && inst_ready && !redirect_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_inst", inst_pc, 32'hDEAD_BEEF);
        end else begin
          x = sb.pop_front();
          check("inst_pc", inst_pc, x.pc);
          check("inst", inst, x.data);
          check("inst_err", 32'(inst_err), 32'(x.err));
        end
      end
    end
  end

  task automatic do_redirect(input logic [31:0] target);
    @(posedge clk);
    force_pc    = target;
    force_redir = 1'b1;
    @(posedge clk);
  endtask

  initial begin : main
    repeat (3) @(negedge clk);
    #3;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_inst_err", 32'(inst_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming, 1-cycle memory, decoder always ready.
    repeat (20) @(posedge clk);
    // Decoder stall: credit must cap requests at DEPTH.
    p_iready = 0;
    repeat (10) @(posedge clk);
    p_iready = 100;
    repeat (10) @(posedge clk);
    // Redirect with requests in flight on a slow memory.
    max_lat = 3;
    repeat (6) @(posedge clk);
    do_redirect(32'h0000_0100);
    repeat (15) @(posedge clk);
    // Access fault at PC 8 halts fetch until redirected.
    max_lat = 0;
    err_addr = 32'h0000_0008;
    do_redirect(32'h0000_0000);
    repeat (15) @(posedge clk);
    @(negedge clk); #2;
    check("halt_no_req", 32'(imem_req_valid), 32'd0);
    do_redirect(32'h0000_0040);
    err_addr = 32'hFFFF_FFFF;
    repeat (15) @(posedge clk);
    // PC wrap-around at the top of the address space.
    do_redirect(32'hFFFF_FFF4);
    repeat (15) @(posedge clk);
    // Random mix of everything.
    p_iready = 70; p_qready = 70; max_lat = 3; p_redir = 20; p_err = 2; auto_unhalt = 1'b1;
    repeat (4000) @(posedge clk);
    @(negedge clk); #5;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
